// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial, LSB-first subtractor: diff = a - b mod 2^WIDTH, stat = borrow-out
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             stat
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             stat_q, stat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    bit_d     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_next   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    res_shift = {bit_d, res_q[WIDTH-1:1]};

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    stat_d  = stat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = '0;
          br_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_next;
        // counter reaches WIDTH on the final bit, which still fits in CW bits
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = res_shift;
          stat_d  = br_next;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      stat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      stat_q  <= stat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign stat = stat_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, minuend; sampled on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH, subtrahend; sampled on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress (RUN or DONE).
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking diff/stat valid.
REQ-009 The block SHALL have port diff, output, WIDTH, result a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port stat, output, 1, borrow-out: 1 when unsigned a < b.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE -> RUN SHALL occur when start=1 at a clk edge; a and b are latched into internal shift registers, the borrow register is cleared, and the bit counter is set to 0.
REQ-013 In RUN, each cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 Each d SHALL shift into the MSB of the internal result register, which shifts right, so that after WIDTH bits bit i sits at position i.
REQ-015 RUN SHALL last exactly WIDTH cycles; RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-016 On RUN -> DONE, diff SHALL load the completed result and stat SHALL load the final borrow.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high during the cycle after edge N+WIDTH.
REQ-019 diff and stat SHALL hold their values from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start SHALL be ignored in RUN and DONE. Operands present at those times are discarded, and no request is queued.
REQ-022 Back-to-back operation: a start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-023 Wrap-around: an unsigned a < b SHALL produce diff = a - b + 2^WIDTH and stat=1; a >= b SHALL produce stat=0.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during RUN.

Reset
REQ-025 While rst=1, the state SHALL be IDLE and busy, done, diff, stat, the counter, the borrow register and both shift registers SHALL be 0, regardless of clk.
REQ-026 Assertion of rst mid-RUN or in DONE SHALL abort the operation with no done pulse, and diff/stat SHALL read 0.
REQ-027 After rst deasserts, the first clk edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, start pulse at edge N -> busy high from N, done high for one cycle after edge N+8, diff=0x02, stat=0.
REQ-029 WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, stat=1; a=0x00, b=0x00 -> diff=0x00, stat=0; a=0x00, b=0xFF -> diff=0x01, stat=1.
REQ-030 WIDTH=8, a=0xFF, b=0x01 accepted, then start held high with a=0x10, b=0x10 through RUN/DONE -> first result 0xFE/stat=0; the held start is accepted in the following IDLE cycle -> 0x00/stat=0, with no lost or extra done pulse.
REQ-031 WIDTH=8, start a=0x80, b=0x01, assert rst after 4 RUN cycles -> busy, done, diff and stat go 0 immediately with no done pulse; after release, a=0x80, b=0x01 -> 0x7F, stat=0.
REQ-032 Random self-check: 1000 random a/b at WIDTH=8 and WIDTH=2 versus a reference model a-b mod 2^WIDTH, with borrow = (a<b) -> zero mismatches, done pulse count equals accepted start count, and done exactly WIDTH+1 edges after each accept.
